// File: rtl/gray_counter.sv
// Registered Gray-code counter: binary state plus a flopped Gray copy, with
// up/down counting, synchronous load and wrap or saturate behaviour at the ends.
module gray_counter #(
  parameter int          WIDTH     = 4,
  parameter bit          SATURATE  = 1'b0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             wrap,
  output logic             sat,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] RST_BIN = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] MAX_BIN = '1;

  logic [WIDTH-1:0] bin_nxt;
  logic             wrap_nxt;
  logic             sat_nxt;

  always_comb begin
    bin_nxt  = bin_q;
    wrap_nxt = 1'b0;
    sat_nxt  = 1'b0;
    if (load) begin
      bin_nxt = load_bin;
    end else if (en) begin
      if (up) begin
        if (bin_q != MAX_BIN) begin
          bin_nxt = bin_q + 1'b1;
        end else if (SATURATE) begin
          sat_nxt = 1'b1;
        end else begin
          bin_nxt  = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (bin_q != '0) begin
          bin_nxt = bin_q - 1'b1;
        end else if (SATURATE) begin
          sat_nxt = 1'b1;
        end else begin
          bin_nxt  = MAX_BIN;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  // Gray is encoded from the next binary value so both outputs come straight off flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= RST_BIN;
      gray_q <= RST_BIN ^ (RST_BIN >> 1);
      wrap   <= 1'b0;
      sat    <= 1'b0;
    end else begin
      bin_q  <= bin_nxt;
      gray_q <= bin_nxt ^ (bin_nxt >> 1);
      wrap   <= wrap_nxt;
      sat    <= sat_nxt;
    end
  end

  assign at_max = (bin_q == MAX_BIN);
  assign at_min = (bin_q == '0);

endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter: wrap, saturate, load priority,
// async reset with non-zero reset value, and 2/12-bit sweeps with direction flips.
module tb_gray_counter;
  logic clk, rst;
  int checks, errors;

  // A: W4 wrap, B: W4 saturate, E: W4 RESET_VAL=5, C: W2, D: W12
  logic a_en, a_up, a_ld; logic [3:0] a_lb, a_bin, a_gray; logic a_wrap, a_sat, a_max, a_min;
  logic b_en, b_up, b_ld; logic [3:0] b_lb, b_bin, b_gray; logic b_wrap, b_sat, b_max, b_min;
  logic e_en, e_up, e_ld; logic [3:0] e_lb, e_bin, e_gray; logic e_wrap, e_sat, e_max, e_min;
  logic s_en, s_up, s_ld;
  logic [1:0]  c_lb, c_bin, c_gray; logic c_wrap, c_sat, c_max, c_min;
  logic [11:0] d_lb, d_bin, d_gray; logic d_wrap, d_sat, d_max, d_min;

  gray_counter #(.WIDTH(4), .SATURATE(1'b0), .RESET_VAL(0)) u_a (
    .clk(clk), .rst(rst), .en(a_en), .up(a_up), .load(a_ld), .load_bin(a_lb),
    .bin_q(a_bin), .gray_q(a_gray), .wrap(a_wrap), .sat(a_sat), .at_max(a_max), .at_min(a_min));
  gray_counter #(.WIDTH(4), .SATURATE(1'b1), .RESET_VAL(0)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .up(b_up), .load(b_ld), .load_bin(b_lb),
    .bin_q(b_bin), .gray_q(b_gray), .wrap(b_wrap), .sat(b_sat), .at_max(b_max), .at_min(b_min));
  gray_counter #(.WIDTH(4), .SATURATE(1'b0), .RESET_VAL(5)) u_e (
    .clk(clk), .rst(rst), .en(e_en), .up(e_up), .load(e_ld), .load_bin(e_lb),
    .bin_q(e_bin), .gray_q(e_gray), .wrap(e_wrap), .sat(e_sat), .at_max(e_max), .at_min(e_min));
  gray_counter #(.WIDTH(2), .SATURATE(1'b0), .RESET_VAL(0)) u_c (
    .clk(clk), .rst(rst), .en(s_en), .up(s_up), .load(s_ld), .load_bin(c_lb),
    .bin_q(c_bin), .gray_q(c_gray), .wrap(c_wrap), .sat(c_sat), .at_max(c_max), .at_min(c_min));
  gray_counter #(.WIDTH(12), .SATURATE(1'b0), .RESET_VAL(0)) u_d (
    .clk(clk), .rst(rst), .en(s_en), .up(s_up), .load(s_ld), .load_bin(d_lb),
    .bin_q(d_bin), .gray_q(d_gray), .wrap(d_wrap), .sat(d_sat), .at_max(d_max), .at_min(d_min));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  gseq [16];
  logic [3:0]  gprev;
  logic [1:0]  mc, gcprev;
  logic [11:0] md, gdprev;
  logic        wc, wd;

  initial begin
    checks = 0; errors = 0;
    gseq[0]=4'h0; gseq[1]=4'h1; gseq[2]=4'h3;  gseq[3]=4'h2;  gseq[4]=4'h6;  gseq[5]=4'h7;
    gseq[6]=4'h5; gseq[7]=4'h4; gseq[8]=4'hC;  gseq[9]=4'hD;  gseq[10]=4'hF; gseq[11]=4'hE;
    gseq[12]=4'hA; gseq[13]=4'hB; gseq[14]=4'h9; gseq[15]=4'h8;
    {a_en, a_up, a_ld, a_lb} = '0; {b_en, b_up, b_ld, b_lb} = '0;
    {e_en, e_up, e_ld, e_lb} = '0; {s_en, s_up, s_ld} = '0; c_lb = '0; d_lb = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_a_bin", a_bin, 0);
    chk("rst_a_gray", a_gray, 0);
    chk("rst_a_min", a_min, 1);
    chk("rst_a_wrap", a_wrap, 0);
    chk("rst_e_bin", e_bin, 5);
    chk("rst_e_gray", e_gray, 4'b0111);
    @(negedge clk) rst = 1'b0;

    // full up cycle on A
    a_en = 1'b1; a_up = 1'b1;
    gprev = a_gray;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("up_gray", a_gray, gseq[i % 16]);
      chk("up_wrap", a_wrap, (i == 16) ? 1 : 0);
      chk("up_onebit", $countones(a_gray ^ gprev), 1);
      chk("up_sat", a_sat, 0);
      gprev = a_gray;
    end
    a_en = 1'b0;
    tick();
    chk("wrap_drop", a_wrap, 0);
    chk("hold_bin", a_bin, 0);

    // down from 0
    a_en = 1'b1; a_up = 1'b0;
    tick();
    chk("dn_bin", a_bin, 15);
    chk("dn_gray", a_gray, 4'b1000);
    chk("dn_wrap", a_wrap, 1);
    chk("dn_max", a_max, 1);
    tick();
    chk("dn2_bin", a_bin, 14);
    chk("dn2_gray", a_gray, 4'b1001);
    chk("dn2_wrap", a_wrap, 0);

    // load beats count
    a_ld = 1'b1; a_lb = 4'd10; a_up = 1'b1;
    tick();
    chk("ld_bin", a_bin, 10);
    chk("ld_gray", a_gray, 4'b1111);
    chk("ld_wrap", a_wrap, 0);
    a_ld = 1'b0;
    tick();
    chk("ld_next_bin", a_bin, 11);
    chk("ld_next_gray", a_gray, 4'b1110);
    a_en = 1'b0;

    // saturate on B
    b_ld = 1'b1; b_lb = 4'd15;
    tick();
    b_ld = 1'b0; b_en = 1'b1; b_up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_bin", b_bin, 15);
      chk("sat_gray", b_gray, 4'b1000);
      chk("sat_flag", b_sat, 1);
      chk("sat_wrap", b_wrap, 0);
    end
    b_up = 1'b0;
    tick();
    chk("unsat_bin", b_bin, 14);
    chk("unsat_flag", b_sat, 0);
    b_ld = 1'b1; b_lb = 4'd0;
    tick();
    b_ld = 1'b0;
    tick();
    chk("sat0_bin", b_bin, 0);
    chk("sat0_flag", b_sat, 1);
    b_en = 1'b0;
    tick();
    chk("sat0_drop", b_sat, 0);

    // async reset on E mid-count
    e_en = 1'b1; e_up = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("e_count9", e_bin, 9);
    #2 rst = 1'b1;
    #1;
    chk("arst_bin", e_bin, 5);
    chk("arst_gray", e_gray, 4'b0111);
    chk("arst_wrap", e_wrap, 0);
    chk("arst_sat", e_sat, 0);
    #1 rst = 1'b0;
    tick();
    chk("resume_bin", e_bin, 6);
    // reset held across an edge overrides a pending load
    #2 rst = 1'b1; e_ld = 1'b1; e_lb = 4'd12;
    tick();
    chk("rst_vs_load", e_bin, 5);
    @(negedge clk) rst = 1'b0; e_ld = 1'b0;
    tick();
    chk("resume2_bin", e_bin, 6);
    e_en = 1'b0;

    // width sweep: C and D sit at 0 after the last reset
    mc = '0; md = '0;
    s_en = 1'b1;
    for (int i = 0; i < 8194; i++) begin
      s_up = (i < 4097) ? 1'b1 : (($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
      gcprev = c_gray; gdprev = d_gray;
      tick();
      if (s_up) begin
        wc = (mc == 2'd3); mc = mc + 2'd1;
        wd = (md == 12'hFFF); md = md + 12'd1;
      end else begin
        wc = (mc == 2'd0); mc = mc - 2'd1;
        wd = (md == 12'd0); md = md - 12'd1;
      end
      chk("c_bin", c_bin, mc);
      chk("c_gray", c_gray, mc ^ (mc >> 1));
      chk("c_wrap", c_wrap, wc);
      chk("c_onebit", $countones(c_gray ^ gcprev), 1);
      chk("d_bin", d_bin, md);
      chk("d_gray", d_gray, md ^ (md >> 1));
      chk("d_wrap", d_wrap, wd);
      chk("d_onebit", $countones(d_gray ^ gdprev), 1);
    end
    s_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
